keypad_cmd_encoder: RTL and testbench
=====================================

# keypad_cmd_encoder

- Input-side counterpart of the calculator's display path.
- Scans a 4x4 matrix keypad, synchronizes and debounces the row returns, and converts each accepted key press into a single-cycle 4-bit `cmd` code for the calculator core.
- Sits between the board keypad pins and the calculator's `cmd` input, inside the calculator top level.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before its rows are sampled; minimum 2.
- `DEBOUNCE`, default 4: consecutive identical samples needed to accept a press or a release; minimum 1.
- `IDLE_CMD`, default 4'hF: value driven on `cmd` when `cmd_valid` is low.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low; forces the reset state immediately.
- `rows` input 4: keypad row returns, asynchronous, active-high.
- `col` output 4: one-hot column drive, active-high.
- `cmd` output 4: key code, valid only while `cmd_valid` = 1.
- `cmd_valid` output 1: one-cycle strobe per accepted press.
- `key_down` output 1: high from the accepted press until the release is accepted.

## Operation
- `rows` passes through a 2-flop synchronizer; all decisions use the synchronized value `rs`.
- A dwell counter counts 0..SCAN_DIV-1 while a column is driven.
  - A sample is taken on the cycle the counter equals SCAN_DIV-1.
  - The counter then wraps to 0.
- Key code = col_idx*4 + row_idx.
  - col_idx is the index of the set bit in `col` (0..3).
  - row_idx is the index of the set bit in `rs`.
- FSM states: SCAN, DEBOUNCE, EMIT, RELEASE.
- SCAN:
  - At each sample, if `rs` has exactly one bit set: capture the code, set match count = 1, hold `col`, go to DEBOUNCE (go to EMIT directly if DEBOUNCE = 1).
  - Otherwise advance `col` 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - A sample with `rs` = 0 or with two or more bits set is ignored (no key).
- DEBOUNCE: `col` stays held.
  - At each sample, if `rs` decodes to the captured code, increment the match count.
  - Otherwise return to SCAN and advance `col`.
  - When the count reaches DEBOUNCE, go to EMIT.
- EMIT: lasts exactly one cycle.
  - `cmd_valid` = 1 and `cmd` = captured code.
  - `key_down` rises in the same cycle.
  - Next state is RELEASE; the dwell counter restarts at 0.
- RELEASE: `col` stays held and `key_down` = 1.
  - At each sample, if `rs` = 0, increment the release count; any nonzero `rs` resets it to 0.
  - When the count reaches DEBOUNCE: clear `key_down`, advance `col`, go to SCAN.
- Other keys:
  - Keys in other columns are invisible while `col` is held.
  - A second key in the same column during RELEASE only delays the release.
  - It never generates a command; at most one `cmd_valid` per physical press.
- Reset asserted at any point (including mid-EMIT):
  - `col` = 0001, `cmd` = IDLE_CMD, `cmd_valid` = 0, `key_down` = 0, state SCAN.
  - All counters and the synchronizer are cleared.
  - A key held through reset release is detected afresh.

## Timing
- All outputs are registered. Reset values: `col` 0001, `cmd` IDLE_CMD, `cmd_valid` 0, `key_down` 0.
- Synchronizer latency is 2 cycles from `rows` to `rs`.
- Press to strobe, with the key stable and its column driven: `cmd_valid` asserts 1 cycle after the DEBOUNCE-th matching sample.
- With the column already driven and the press aligned to dwell start: latency = 2 + DEBOUNCE*SCAN_DIV cycles maximum, plus up to 3*SCAN_DIV cycles to reach the column.
- `cmd_valid` is never high for two consecutive cycles.
- The minimum spacing between two strobes is 2*DEBOUNCE*SCAN_DIV cycles.
- `col` changes only on the cycle after a sample, or on reset.

## Test plan
Use SCAN_DIV = 4 and DEBOUNCE = 3 for all scenarios.
- Reset: with `reset` held low, `col` = 0001, `cmd` = F, `cmd_valid` = 0. Releasing reset with no key pressed -> `col` rotates every 4 cycles, 0001/0010/0100/1000/0001.
- Clean press: hold rows = 0100 whenever col = 0010 -> exactly one `cmd_valid` with `cmd` = 4'h6. `col` stays 0010 until rows stay 0 for 3 samples, then `key_down` falls and `col` = 0100.
- Bounce: rows = 0001 at col = 1000, dropping to 0 at the 2nd sample -> no strobe, `col` advances to 0001. A stable press after that -> one strobe with `cmd` = 4'hC.
- Release bounce: a held key toggling 0/1 during RELEASE -> no second strobe, and `key_down` stays 1 until 3 consecutive zero samples.
- Multi-key: rows = 0011 at col = 0001 -> ignored, no strobe. Pressing a second key in col 0001 while the first is held -> no extra strobe.
- Async reset asserted in the EMIT cycle -> `cmd_valid` drops immediately, `cmd` = F, `col` = 0001. After reset release, the still-held key produces one new strobe.

Source files
------------

// File: rtl/keypad_cmd_encoder_if.sv
// ---------------------------------------------------------------------------
// keypad_cmd_encoder_if
// Bundles the keypad pins and the command strobe that the keypad encoder
// exchanges with the board and with the calculator core.
//
// Signals:
//   rows      - keypad row returns (asynchronous, active-high)
//   col       - one-hot column drive (active-high)
//   cmd       - 4-bit key code, meaningful only while cmd_valid is high
//   cmd_valid - single-cycle strobe per accepted key press
//   key_down  - high from an accepted press until its release is accepted
//
// Modports:
//   master - the encoder: samples rows, drives everything else
//   slave  - the keypad/core side: drives rows, observes everything else
// ---------------------------------------------------------------------------
interface keypad_cmd_encoder_if;
   logic [3:0] rows;
   logic [3:0] col;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       key_down;

   modport master (
      input  rows,
      output col,
      output cmd,
      output cmd_valid,
      output key_down
   );

   modport slave (
      output rows,
      input  col,
      input  cmd,
      input  cmd_valid,
      input  key_down
   );
endinterface

// File: rtl/keypad_cmd_encoder.sv
// ---------------------------------------------------------------------------
// keypad_cmd_encoder
// Scans a 4x4 matrix keypad one column at a time, synchronizes and debounces
// the row returns, and turns each accepted press into a single-cycle 4-bit
// command code (code = column index * 4 + row index).
//
// Parameters:
//   SCAN_DIV - cycles each column is driven before its rows are sampled (>= 2)
//   DEBOUNCE - consecutive identical samples to accept a press or release (>= 1)
//   IDLE_CMD - value on cmd while cmd_valid is low
//
// Ports:
//   clock - single clock, rising edge
//   reset - asynchronous, active-low
//   kp    - keypad_cmd_encoder_if.master (rows in; col, cmd, cmd_valid,
//           key_down out, all registered)
// ---------------------------------------------------------------------------
module keypad_cmd_encoder #(
   parameter int         SCAN_DIV = 1000,
   parameter int         DEBOUNCE = 4,
   parameter logic [3:0] IDLE_CMD = 4'hF
) (
   input logic                  clock,
   input logic                  reset,
   keypad_cmd_encoder_if.master kp
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_EMIT,
      ST_RELEASE
   } state_t;

   state_t           state;
   logic [3:0]       rows_meta;
   logic [3:0]       rs;
   logic [CNT_W-1:0] dwell;
   logic [DEB_W-1:0] match_cnt;
   logic [DEB_W-1:0] rel_cnt;
   logic [3:0]       code;
   logic [3:0]       col_q;
   logic [3:0]       cmd_q;
   logic             cmd_valid_q;
   logic             key_down_q;

   logic             sample;
   logic             rs_one_hot;
   logic [1:0]       row_idx;
   logic [1:0]       col_idx;
   logic [3:0]       cur_code;
   logic [3:0]       col_next;

   assign kp.col       = col_q;
   assign kp.cmd       = cmd_q;
   assign kp.cmd_valid = cmd_valid_q;
   assign kp.key_down  = key_down_q;

   assign sample     = (dwell == CNT_LAST);
   assign rs_one_hot = (rs != 4'd0) && ((rs & (rs - 4'd1)) == 4'd0);
   assign cur_code   = {col_idx, row_idx};
   assign col_next   = {col_q[2:0], col_q[3]};

   // Turn the one-hot row return and column drive into binary indices.
   // Only meaningful when rs is one-hot; other patterns are rejected
   // before cur_code is ever used.
   always_comb begin
      row_idx = 2'd0;
      case (rs)
         4'b0010: row_idx = 2'd1;
         4'b0100: row_idx = 2'd2;
         4'b1000: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
      col_idx = 2'd0;
      case (col_q)
         4'b0010: col_idx = 2'd1;
         4'b0100: col_idx = 2'd2;
         4'b1000: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   // Two-flop synchronizer: the row returns come straight off the board and
   // can change at any time, so nothing downstream looks at them raw.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rows_meta <= 4'd0;
         rs        <= 4'd0;
      end else begin
         rows_meta <= kp.rows;
         rs        <= rows_meta;
      end
   end

   // Dwell counter: sets the pace of sampling. It also restarts during the
   // emit cycle so the release phase gets a full dwell before its first
   // sample.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dwell <= '0;
      end else if (sample || state == ST_EMIT) begin
         dwell <= '0;
      end else begin
         dwell <= dwell + CNT_W'(1);
      end
   end

   // Main scan/debounce FSM. Every output is a register updated here, so
   // cmd_valid and key_down go high in the cycle after the accepting sample,
   // and col only moves on the edge where a sample is taken.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_SCAN;
         match_cnt   <= '0;
         rel_cnt     <= '0;
         code        <= 4'd0;
         col_q       <= 4'b0001;
         cmd_q       <= IDLE_CMD;
         cmd_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         cmd_valid_q <= 1'b0;
         cmd_q       <= IDLE_CMD;
         case (state)
            ST_SCAN: begin
               if (sample) begin
                  if (rs_one_hot) begin
                     code      <= cur_code;
                     match_cnt <= DEB_W'(1);
                     if (DEBOUNCE == 1) begin
                        state       <= ST_EMIT;
                        cmd_q       <= cur_code;
                        cmd_valid_q <= 1'b1;
                        key_down_q  <= 1'b1;
                     end else begin
                        state <= ST_DEBOUNCE;
                     end
                  end else begin
                     col_q <= col_next;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (sample) begin
                  if (rs_one_hot && cur_code == code) begin
                     if (match_cnt == DEB_LAST) begin
                        state       <= ST_EMIT;
                        cmd_q       <= code;
                        cmd_valid_q <= 1'b1;
                        key_down_q  <= 1'b1;
                     end else begin
                        match_cnt <= match_cnt + DEB_W'(1);
                     end
                  end else begin
                     state <= ST_SCAN;
                     col_q <= col_next;
                  end
               end
            end
            ST_EMIT: begin
               state   <= ST_RELEASE;
               rel_cnt <= '0;
            end
            ST_RELEASE: begin
               if (sample) begin
                  if (rs == 4'd0) begin
                     if (rel_cnt == DEB_LAST) begin
                        state      <= ST_SCAN;
                        key_down_q <= 1'b0;
                        col_q      <= col_next;
                     end else begin
                        rel_cnt <= rel_cnt + DEB_W'(1);
                     end
                  end else begin
                     rel_cnt <= '0;
                  end
               end
            end
            default: begin
               state <= ST_SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// ---------------------------------------------------------------------------
// tb_keypad_cmd_encoder
// Drives a modelled 4x4 keypad (a 16-bit pressed-key vector, key = col*4+row)
// into keypad_cmd_encoder with SCAN_DIV = 4 and DEBOUNCE = 3, and compares
// its outputs against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_keypad_cmd_encoder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] keys  = 16'd0;
   logic [3:0]  rows_model;

   int n_checks     = 0;
   int n_errors     = 0;
   int strobes      = 0;
   int double_valid = 0;
   logic prev_valid = 1'b0;

   typedef struct {
      int         key;
      logic [3:0] exp_cmd;
      logic [3:0] exp_col;
      logic [3:0] exp_next_col;
   } vec_t;

   vec_t vecs[6];

   keypad_cmd_encoder_if kp();

   keypad_cmd_encoder #(
      .SCAN_DIV (4),
      .DEBOUNCE (3),
      .IDLE_CMD (4'hF)
   ) dut (
      .clock (clock),
      .reset (reset),
      .kp    (kp)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Keypad matrix model: a row return is high when a pressed key sits in
   // the column currently being driven.
   always_comb begin
      rows_model = 4'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (kp.col[c] && keys[c*4 + r]) begin
               rows_model[r] = 1'b1;
            end
         end
      end
   end

   assign kp.rows = rows_model;

   // Strobe monitor: counts accepted presses and records any cmd_valid that
   // stays high for two cycles in a row.
   always @(negedge clock) begin
      if (kp.cmd_valid) begin
         strobes <= strobes + 1;
         if (prev_valid) begin
            double_valid <= double_valid + 1;
         end
      end
      prev_valid <= kp.cmd_valid;
   end

   // Safety net so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task applyStimulus(input logic [15:0] k);
      keys = k;
   endtask

   task wait_strobe(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (kp.cmd_valid) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({name, " strobe seen"}, 32'(ok), 32'd1);
   endtask

   task wait_key_up(input string name, output int cycles);
      logic ok;
      ok     = 1'b0;
      cycles = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         cycles++;
         if (!kp.key_down) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({name, " key_down falls"}, 32'(ok), 32'd1);
   endtask

   task wait_col(input string name, input logic [3:0] c);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (kp.col == c) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({name, " column reached"}, 32'(ok), 32'd1);
   endtask

   // Main test sequence.
   initial begin
      logic [3:0] rot_exp[4];
      logic [3:0] old_col;
      int         n;
      int         base;
      int         cyc;
      int         lows;
      int         changes;

      vecs[0] = '{key: 6,  exp_cmd: 4'h6, exp_col: 4'b0010, exp_next_col: 4'b0100};
      vecs[1] = '{key: 12, exp_cmd: 4'hC, exp_col: 4'b1000, exp_next_col: 4'b0001};
      vecs[2] = '{key: 0,  exp_cmd: 4'h0, exp_col: 4'b0001, exp_next_col: 4'b0010};
      vecs[3] = '{key: 15, exp_cmd: 4'hF, exp_col: 4'b1000, exp_next_col: 4'b0001};
      vecs[4] = '{key: 9,  exp_cmd: 4'h9, exp_col: 4'b0100, exp_next_col: 4'b1000};
      vecs[5] = '{key: 3,  exp_cmd: 4'h3, exp_col: 4'b0001, exp_next_col: 4'b0010};

      rot_exp[0] = 4'b0010;
      rot_exp[1] = 4'b0100;
      rot_exp[2] = 4'b1000;
      rot_exp[3] = 4'b0001;

      // Reset state while reset is held low
      applyStimulus(16'd0);
      repeat (3) @(negedge clock);
      checkOutput("reset col", 32'(kp.col), 32'h1);
      checkOutput("reset cmd", 32'(kp.cmd), 32'hF);
      checkOutput("reset cmd_valid", 32'(kp.cmd_valid), 32'h0);
      checkOutput("reset key_down", 32'(kp.key_down), 32'h0);

      // Idle column rotation, one step every 4 cycles
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         old_col = kp.col;
         n = 0;
         do begin
            @(negedge clock);
            n++;
         end while (kp.col == old_col && n < 20);
         checkOutput($sformatf("rotate period %0d", i), 32'(n), 32'd4);
         checkOutput($sformatf("rotate col %0d", i), 32'(kp.col), 32'(rot_exp[i]));
      end

      // Table-driven single clean presses
      for (int i = 0; i < 6; i++) begin
         base = strobes;
         applyStimulus(16'h0001 << vecs[i].key);
         wait_strobe($sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d cmd", i), 32'(kp.cmd), 32'(vecs[i].exp_cmd));
         checkOutput($sformatf("vec%0d key_down", i), 32'(kp.key_down), 32'd1);
         checkOutput($sformatf("vec%0d held col", i), 32'(kp.col), 32'(vecs[i].exp_col));
         @(negedge clock);
         checkOutput($sformatf("vec%0d single-cycle valid", i), 32'(kp.cmd_valid), 32'd0);
         checkOutput($sformatf("vec%0d idle cmd", i), 32'(kp.cmd), 32'hF);
         repeat (12) @(negedge clock);
         checkOutput($sformatf("vec%0d col still held", i), 32'(kp.col), 32'(vecs[i].exp_col));
         checkOutput($sformatf("vec%0d still down", i), 32'(kp.key_down), 32'd1);
         applyStimulus(16'd0);
         wait_key_up($sformatf("vec%0d", i), cyc);
         checkOutput($sformatf("vec%0d col after release", i), 32'(kp.col), 32'(vecs[i].exp_next_col));
         @(negedge clock);
         checkOutput($sformatf("vec%0d strobe count", i), 32'(strobes - base), 32'd1);
      end

      // Bounce: key 12 seen at the first sample, gone at the second
      base = strobes;
      wait_col("bounce", 4'b1000);
      applyStimulus(16'h1000);
      repeat (4) @(negedge clock);
      applyStimulus(16'd0);
      wait_col("bounce advance", 4'b0001);
      checkOutput("bounce no strobe", 32'(strobes - base), 32'd0);
      checkOutput("bounce key_down", 32'(kp.key_down), 32'd0);
      applyStimulus(16'h1000);
      wait_strobe("bounce retry");
      checkOutput("bounce retry cmd", 32'(kp.cmd), 32'hC);
      applyStimulus(16'd0);
      wait_key_up("bounce retry", cyc);
      @(negedge clock);
      checkOutput("bounce retry strobe count", 32'(strobes - base), 32'd1);

      // Release bounce: key 9 toggling once per sample period
      base = strobes;
      applyStimulus(16'h0200);
      wait_strobe("relbounce");
      checkOutput("relbounce cmd", 32'(kp.cmd), 32'h9);
      lows = 0;
      for (int p = 0; p < 10; p++) begin
         applyStimulus((p % 2 == 1) ? 16'h0200 : 16'h0000);
         repeat (4) begin
            @(negedge clock);
            if (!kp.key_down) lows++;
         end
      end
      repeat (8) begin
         @(negedge clock);
         if (!kp.key_down) lows++;
      end
      checkOutput("relbounce key_down held", 32'(lows), 32'd0);
      applyStimulus(16'd0);
      wait_key_up("relbounce", cyc);
      checkOutput("relbounce release time 11..14", 32'(cyc >= 11 && cyc <= 14), 32'd1);
      @(negedge clock);
      checkOutput("relbounce strobe count", 32'(strobes - base), 32'd1);

      // Multi-key: two rows in column 0 are ignored and the scan keeps moving
      base = strobes;
      applyStimulus(16'h0003);
      changes = 0;
      old_col = kp.col;
      repeat (40) begin
         @(negedge clock);
         if (kp.col != old_col) changes++;
         old_col = kp.col;
      end
      checkOutput("multikey no strobe", 32'(strobes - base), 32'd0);
      checkOutput("multikey scan continues", 32'(changes >= 9), 32'd1);

      // Second key in the held column only delays the release
      applyStimulus(16'h0001);
      wait_strobe("samecol");
      checkOutput("samecol cmd", 32'(kp.cmd), 32'h0);
      applyStimulus(16'h0005);
      repeat (20) @(negedge clock);
      applyStimulus(16'h0004);
      repeat (30) @(negedge clock);
      checkOutput("samecol key_down held", 32'(kp.key_down), 32'd1);
      checkOutput("samecol col held", 32'(kp.col), 32'h1);
      applyStimulus(16'd0);
      wait_key_up("samecol", cyc);
      @(negedge clock);
      checkOutput("samecol strobe count", 32'(strobes - base), 32'd1);

      // Async reset in the EMIT cycle, key 5 held throughout
      base = strobes;
      applyStimulus(16'h0020);
      wait_strobe("rst-emit");
      checkOutput("rst-emit cmd before reset", 32'(kp.cmd), 32'h5);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rst-emit cmd_valid", 32'(kp.cmd_valid), 32'd0);
      checkOutput("rst-emit cmd", 32'(kp.cmd), 32'hF);
      checkOutput("rst-emit col", 32'(kp.col), 32'h1);
      checkOutput("rst-emit key_down", 32'(kp.key_down), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      wait_strobe("rst-emit redetect");
      checkOutput("rst-emit redetect cmd", 32'(kp.cmd), 32'h5);
      applyStimulus(16'd0);
      wait_key_up("rst-emit", cyc);
      @(negedge clock);
      checkOutput("rst-emit strobe count", 32'(strobes - base), 32'd2);

      checkOutput("no back-to-back cmd_valid", 32'(double_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
